regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-port arbiter and scheduler for the single-write-port 32x32 register file. Shares the one write port between two writeback sources:
- **Port A**: single-cycle ALU results, unbuffered, normally highest priority.
- **Port B**: multi-cycle results (load/mul/div), buffered in a small FIFO.

An aging counter stops B from starving under continuous A traffic. The block drives the register file's write-enable, write-address and write-data directly from registered outputs.

## Interface
Parameters:
- DEPTH, 2, port-B FIFO depth; power of two, ≥2
- MAX_WAIT, 4, cycles a B head entry may lose arbitration before it is force-granted; ≥1
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- a_valid  in  1  port A write request
- a_wa  in  AW  port A destination register
- a_wd  in  DW  port A write data
- a_ready  out  1  port A accepted this cycle when a_valid && a_ready
- b_valid  in  1  port B write request
- b_wa  in  AW  port B destination register
- b_wd  in  DW  port B write data
- b_ready  out  1  port B accepted into FIFO when b_valid && b_ready
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  AW  register-file write address (registered)
- rf_wd  out  DW  register-file write data (registered)
- b_count  out  $clog2(DEPTH+1)  FIFO occupancy
- idle  out  1  FIFO empty && !rf_we

## Operation
- `force_b = !empty && wait_cnt == MAX_WAIT`.
- `a_ready = !force_b` (combinational; independent of a_valid).
- `b_ready = !full`. There is no pass-through when full, even if the head pops the same cycle.
- Winner selection each cycle, exactly one or none:
  1. force_b → FIFO head
  2. else a_valid → A
  3. else !empty → FIFO head
  4. else none
- A FIFO pop occurs only when the head is the winner. Push and pop in the same cycle are allowed whenever not full.
- Output register, when there is a winner:
  - `rf_we <= (winner_wa != 0)`.
  - rf_wa and rf_wd load the winner's fields.
- Output register, when there is no winner: `rf_we <= 0`; rf_wa and rf_wd hold.
- Writes to register 0 are consumed (handshake completes, FIFO pops) but never assert rf_we.
- wait_cnt:
  - Cleared when the FIFO is empty or the head pops.
  - Otherwise incremented when the head is present and loses.
  - Saturates at MAX_WAIT.
- Ordering: writes from the same port retire in acceptance order. No ordering between A and B to the same register is enforced; hazard avoidance is the issuing stage's responsibility.

## Timing
- Reset (rst_n low at a rising edge):
  - FIFO emptied (pending entries dropped, including mid-operation)
  - wait_cnt = 0, rf_we = 0, rf_wa = 0, rf_wd = 0, b_count = 0
  - Post-reset a_ready = 1, b_ready = 1, idle = 1
- A latency: accepted in cycle t → rf_we/rf_wa/rf_wd valid in cycle t+1. The register file writes at the end of t+1.
- B latency, no contention: pushed in cycle t → head eligible in t+1 → rf_we in t+2.
- B worst case with A valid every cycle: head first present in t → force-granted in t+MAX_WAIT → rf_we in t+MAX_WAIT+1. In the force cycle a_ready = 0 and A must hold its request.
- Full FIFO: b_ready = 0 in the same cycle that count reaches DEPTH.
- Wrap-around: read/write pointers are log2(DEPTH) bits plus a wrap bit. full and empty are distinguished by the wrap bit.
- Sustained throughput: one write per cycle on the output.

## Structure
- Package `regfile_pkg`:
  - AW and DW constants
  - `ZERO_REG = '0`
  - `typedef struct packed {logic [AW-1:0] wa; logic [DW-1:0] wd;} wb_req_t`
- Sub-module `wb_fifo`: synchronous FIFO of wb_req_t. Parameter DEPTH; ports push, pop, full, empty, count, head. Registered storage, no bypass.
- Top level contains the arbitration logic, wait_cnt, and the output register.

## Test plan
- Reset mid-traffic: 2 B entries queued, assert rst_n=0 for one edge → b_count=0, rf_we=0, rf_wa=0, rf_wd=0, idle=1; the dropped entries are never written.
- A only: a_valid with wa=3, wd=0xDEADBEEF at cycle 5 → rf_we=1, rf_wa=3, rf_wd=0xDEADBEEF at cycle 6. Then a_valid=0 → rf_we=0 at cycle 7.
- B aging, MAX_WAIT=4: push B(wa=7, wd=0x11) at cycle 0 with A valid every cycle → a_ready=0 at cycle 5 only; rf_wa=7 at cycle 6; A writes in all other cycles.
- FIFO full: push 3 B requests back-to-back with a_valid held high → b_ready=0 after 2 pushes, b_count=2. Third request is accepted one cycle after the first pop. Order is preserved.
- Register-0 writes: A wa=0, wd=0x55 → a_ready=1, rf_we stays 0. B wa=0 → popped, b_count decrements, rf_we stays 0.
- Simultaneous push/pop: FIFO holds 1 entry, a_valid=0, b_valid=1 → head written next cycle, b_count stays 1, wait_cnt=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and the writeback request type for the register-file write port
package regfile_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] ZERO_REG = '0;
    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback requests with wrap-bit pointers and registered storage
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  wb_req_t                      din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output wb_req_t                      head
);
    localparam int PW = $clog2(DEPTH);
    logic [PW:0] wp;
    logic [PW:0] rp;
    wb_req_t     mem [DEPTH];
    logic        do_push;
    logic        do_pop;
    assign empty   = wp == rp;
    assign full    = wp == {~rp[PW], rp[PW-1:0]};
    assign count   = wp - rp;
    assign head    = mem[rp[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[PW-1:0]] <= din;
    end
    // pointer advance; reset drops every queued entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU results and buffered multi-cycle results
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4,
    parameter int AW       = 5,
    parameter int DW       = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_valid,
    input  logic [AW-1:0]                a_wa,
    input  logic [DW-1:0]                a_wd,
    output logic                         a_ready,
    input  logic                         b_valid,
    input  logic [AW-1:0]                b_wa,
    input  logic [DW-1:0]                b_wd,
    output logic                         b_ready,
    output logic                         rf_we,
    output logic [AW-1:0]                rf_wa,
    output logic [DW-1:0]                rf_wd,
    output logic [$clog2(DEPTH+1)-1:0]   b_count,
    output logic                         idle
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    wb_req_t       head;
    wb_req_t       b_req;
    logic          full;
    logic          empty;
    logic          force_b;
    logic          pick_b;
    logic          win;
    logic [AW-1:0] win_wa;
    logic [DW-1:0] win_wd;
    logic [WW-1:0] wait_cnt;
    assign b_req   = '{wa: b_wa, wd: b_wd};
    assign force_b = !empty && wait_cnt == WW'(MAX_WAIT);
    assign a_ready = !force_b;
    assign b_ready = !full;
    assign pick_b  = force_b || (!a_valid && !empty);
    assign win     = pick_b || a_valid;
    assign win_wa  = pick_b ? head.wa : a_wa;
    assign win_wd  = pick_b ? head.wd : a_wd;
    assign idle    = empty && !rf_we;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (b_valid),
        .pop   (pick_b),
        .din   (b_req),
        .full  (full),
        .empty (empty),
        .count (b_count),
        .head  (head)
    );

    // aging: count arbitration losses of the current head, saturating at the force threshold
    always_ff @(posedge clk) begin
        if (!rst_n) wait_cnt <= '0;
        else if (empty || pick_b) wait_cnt <= '0;
        else if (!force_b) wait_cnt <= wait_cnt + WW'(1);
    end
    // output register; register-0 writes are consumed without raising the enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= win && win_wa != ZERO_REG;
            if (win) begin
                rf_wa <= win_wa;
                rf_wd <= win_wd;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks against a queue-based model of the write-port arbiter
module tb_regfile_wb_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_wa = '0;
    logic [31:0] a_wd = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_wa = '0;
    logic [31:0] b_wd = '0;
    logic        b_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [1:0]  b_count;
    logic        idle;

    int total = 0;
    int bad = 0;
    int ar_low = 0;

    // model: pending B requests in arrival order, losses of the current head, expected output register
    logic [36:0] q[$];
    int          age = 0;
    logic        e_we = 1'b0;
    logic [4:0]  e_wa = '0;
    logic [31:0] e_wd = '0;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .AW(5), .DW(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_wa    (a_wa),
        .a_wd    (a_wd),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_wa    (b_wa),
        .b_wd    (b_wd),
        .b_ready (b_ready),
        .rf_we   (rf_we),
        .rf_wa   (rf_wa),
        .rf_wd   (rf_wd),
        .b_count (b_count),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, check handshake outputs, advance the model, check the output register
    task automatic step(input logic rn, input logic av, input logic [4:0] awa, input logic [31:0] awd,
                        input logic bv, input logic [4:0] bwa, input logic [31:0] bwd);
        bit          frc;
        bit          has_room;
        logic [36:0] ent;
        rst_n = rn; a_valid = av; a_wa = awa; a_wd = awd;
        b_valid = bv; b_wa = bwa; b_wd = bwd;
        #1;
        frc = q.size() > 0 && age >= MAX_WAIT;
        has_room = q.size() < DEPTH;
        if (!a_ready) ar_low++;
        check("a_ready", a_ready, !frc);
        check("b_ready", b_ready, has_room);
        check("b_count", b_count, q.size());
        check("idle", idle, q.size() == 0 && !e_we);
        if (!rn) begin
            q.delete();
            age = 0;
            e_we = 0; e_wa = 0; e_wd = 0;
        end else begin
            if (q.size() > 0 && (frc || !av)) begin
                ent = q.pop_front();
                e_we = ent[36:32] != 0; e_wa = ent[36:32]; e_wd = ent[31:0];
                age = 0;
            end else if (av) begin
                e_we = awa != 0; e_wa = awa; e_wd = awd;
                if (q.size() > 0) age = age + 1;
            end else begin
                e_we = 0;
            end
            if (bv && has_room) q.push_back({bwa, bwd});
            if (q.size() == 0) age = 0;
        end
        @(posedge clk);
        #1;
        check("rf_we", rf_we, e_we);
        check("rf_wa", rf_wa, e_wa);
        check("rf_wd", rf_wd, e_wd);
        @(negedge clk);
    endtask

    initial begin
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_wa", rf_wa, 0);
        check("rst_rf_wd", rf_wd, 0);
        check("rst_count", b_count, 0);
        check("rst_idle", idle, 1);
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);

        // reset mid-traffic: two B entries queued behind A traffic, then dropped
        step(1, 1, 5'd1, 32'h1, 1, 5'd9, 32'h99);
        step(1, 1, 5'd2, 32'h2, 1, 5'd10, 32'hAA);
        check("mid_count2", b_count, 2);
        step(0, 1, 5'd3, 32'h3, 0, 0, 0);
        check("mid_rst_count", b_count, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_idle", idle, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);

        // A only
        step(1, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
        check("a_only_wd", rf_wd, 32'hDEADBEEF);
        check("a_only_we", rf_we, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        check("a_only_off", rf_we, 0);

        // B aging under continuous A traffic
        ar_low = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 5'(8 + i), 32'(i), i == 0, 5'd7, 32'h11);
            if (i == 5) check("age_wa", rf_wa, 7);
        end
        check("age_force_once", ar_low, 1);

        // FIFO full with A held: third B waits for the first forced pop
        for (int i = 0; i < 12; i++) step(1, 1, 5'd4, 32'(i), i < 8, 5'(20 + i), 32'(100 + i));
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 0);

        // register-0 writes from both ports
        step(1, 1, 5'd0, 32'h55, 0, 0, 0);
        check("a_zero_we", rf_we, 0);
        step(1, 0, 0, 0, 1, 5'd0, 32'h66);
        step(1, 0, 0, 0, 0, 0, 0);
        check("b_zero_we", rf_we, 0);

        // simultaneous push and pop with one queued entry
        step(1, 0, 0, 0, 1, 5'd12, 32'h1234);
        step(1, 0, 0, 0, 1, 5'd13, 32'h5678);
        check("pp_count", b_count, 1);
        step(1, 0, 0, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, 5'($urandom_range(0, 6)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 6)), $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
